// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-bit shift controller for an external 1-bit-per-pass shifter.
//   A request is held in an accumulator that is pushed through the shifter
//   once per clock. Each result is written back into the accumulator until
//   the requested number of passes has been applied.
//
//   state | meaning
//   IDLE  | waiting for start; shifter idles as pass-through
//   RUN   | one shifter pass per clock, cnt counts down to 1
//   DONE  | one-cycle done pulse; dout valid; start accepted back-to-back
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request strobe, sampled only when busy=0
//   op        shift code: 00 none, 01 left, 10 logical right, 11 arith right
//   amount    number of 1-bit passes
//   din       operand
//   sh_in     to shifter data input (accumulator)
//   sh_shift  to shifter shift select (00 outside RUN)
//   sh_out    from shifter output (combinational)
//   abort     (only with SHIFT_SEQ_ABORT_EN) abandons a RUN without done
//   busy      high while in RUN
//   done      one-cycle pulse when dout is valid
//   dout      result, held until the next completed request
//
// Optional feature macro: SHIFT_SEQ_ABORT_EN adds the abort input.

module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sh_in,
    output logic [1:0]       sh_shift,
    input  logic [WIDTH-1:0] sh_out,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_abort;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // dout is loaded on the edge that enters DONE so that it is already
    // valid while done is high.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_dout_nxt  = r_dout;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (start) begin
                    w_acc_nxt = din;
                    w_op_nxt  = op;
                    w_cnt_nxt = amount;
                    if (amount == '0 || op == 2'b00) begin
                        w_state_nxt = DONE;
                        w_dout_nxt  = din;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                w_acc_nxt = sh_out;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                    w_dout_nxt  = sh_out;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign sh_shift = (r_state == RUN) ? r_op : 2'b00;
    assign sh_in    = r_acc;
    assign dout     = r_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] din;
    logic [15:0] sh_in;
    logic [1:0]  sh_shift;
    logic [15:0] sh_out;
    logic        busy;
    logic        done;
    logic [15:0] dout;
`ifdef SHIFT_SEQ_ABORT_EN
    logic        abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .amount   (amount),
        .din      (din),
        .sh_in    (sh_in),
        .sh_shift (sh_shift),
        .sh_out   (sh_out),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .dout     (dout)
    );

    // external 1-bit shifter
    always_comb begin
        case (sh_shift)
            2'b01:   sh_out = {sh_in[14:0], 1'b0};
            2'b10:   sh_out = {1'b0, sh_in[15:1]};
            2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
            default: sh_out = sh_in;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // call at a negedge; drives a request across the next rising edge
    task automatic drive_start(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
        start  = 1'b1;
        op     = o;
        amount = a;
        din    = d;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic go(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        drive_start(o, a, d);
    endtask

    // counts negedges after the start edge until done; returns at that negedge
    task automatic wait_done(input int c0, output int lat, output int busy_n, output int nz);
        bit seen;
        lat = c0; busy_n = 0; nz = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (sh_shift != 2'b00) nz++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    int lat, bn, nz, cnt;

    initial begin
        reset_n = 1'b0;
        start = 1'b0; op = 2'b00; amount = 4'd0; din = 16'h0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_shift", sh_shift, 2'b00);
        chk("rst_shin", sh_in, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // left 3 of 0x0001
        go(2'b01, 4'd3, 16'h0001);
        wait_done(0, lat, bn, nz);
        chk("l3_lat", lat, 4);
        chk("l3_busy", bn, 3);
        chk("l3_dout", dout, 16'h0008);
        @(negedge clk);
        chk("l3_done_single", done, 0);
        chk("l3_hold", dout, 16'h0008);

`ifdef SHIFT_SEQ_ABORT_EN
        go(2'b01, 4'd10, 16'h0001);
        repeat (2) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("ab_nodone", cnt, 0);
        chk("ab_dout", dout, 16'h0008);
`endif

        go(2'b11, 4'd4, 16'h8000);
        wait_done(0, lat, bn, nz);
        chk("asr4_lat", lat, 5);
        chk("asr4_dout", dout, 16'hF800);

        go(2'b10, 4'd4, 16'h8000);
        wait_done(0, lat, bn, nz);
        chk("lsr4_lat", lat, 5);
        chk("lsr4_dout", dout, 16'h0800);

        go(2'b01, 4'd0, 16'h1234);
        wait_done(0, lat, bn, nz);
        chk("z_lat", lat, 1);
        chk("z_dout", dout, 16'h1234);
        chk("z_shift", nz, 0);

        go(2'b00, 4'd5, 16'hABCD);
        wait_done(0, lat, bn, nz);
        chk("op0_lat", lat, 1);
        chk("op0_dout", dout, 16'hABCD);
        chk("op0_shift", nz, 0);

        // start during RUN is ignored, then chained start in DONE
        go(2'b01, 4'd2, 16'h0003);
        @(negedge clk);
        chk("poke_busy", busy, 1);
        drive_start(2'b10, 4'd1, 16'hFFFF);
        wait_done(1, lat, bn, nz);
        chk("poke_lat", lat, 3);
        chk("poke_dout", dout, 16'h000C);
        drive_start(2'b10, 4'd1, 16'h0002);
        wait_done(0, lat, bn, nz);
        chk("chain_lat", lat, 2);
        chk("chain_dout", dout, 16'h0001);
        @(negedge clk);
        chk("chain_single", done, 0);

        go(2'b11, 4'd15, 16'h8000);
        wait_done(0, lat, bn, nz);
        chk("asr15_lat", lat, 16);
        chk("asr15_dout", dout, 16'hFFFF);

        go(2'b01, 4'd15, 16'hFFFF);
        wait_done(0, lat, bn, nz);
        chk("l15_dout", dout, 16'h8000);

        // asynchronous reset during RUN
        go(2'b01, 4'd5, 16'h0001);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_dout", dout, 16'h0000);
        chk("mrst_shift", sh_shift, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("mrst_nodone", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
